// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// The fetch queue entry pairs a fetched word with the address it came from.
package if_fetch_pkg;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } fetch_entry_t;

    // Instruction fetches are word aligned; the low two address bits are dropped.
    function automatic logic [63:0] align_word(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order buffer of fetched {addr,data} entries presented to decode.
// Flush empties the queue and discards any same-cycle push or pop.
module fetch_queue
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_ok;

    assign empty  = (count == '0);
    assign pop_ok = pop && !empty;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop_ok);
        end
    end

    // NOTE: the storage array has no reset; count/pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // The credit rule in the producer keeps a push away from a full queue.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && !pop_ok && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, issues in-order word reads to imem,
// buffers returned words and hands them to decode; redirects drop older fetches.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,

    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,

    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [63:0] inst_addr_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);

    logic [63:0]      pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W:0]   credit_used;

    // Addresses of in-flight requests, in issue order; occupancy equals outstanding.
    logic [63:0]      addr_mem [DEPTH];
    logic [PTR_W-1:0] aw_ptr;
    logic [PTR_W-1:0] ar_ptr;

    logic         req_fire;
    logic         rsp_take;
    logic         q_push;
    logic         q_pop;
    logic         q_empty;
    fetch_entry_t q_head;
    fetch_entry_t rsp_entry;

    assign credit_used    = {1'b0, outstanding} + {1'b0, q_count};
    assign imem_req_valid = rst_n && (credit_used < (CNT_W+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding belongs to a pre-reset request.
    assign rsp_take  = imem_rsp_valid && (outstanding != '0);
    assign q_push    = rsp_take && (drop_cnt == '0) && !redirect_valid;
    assign q_pop     = inst_valid_o && inst_ready_i;
    assign rsp_entry = '{addr: addr_mem[ar_ptr], data: imem_rsp_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            aw_ptr      <= '0;
            ar_ptr      <= '0;
        end else begin
            if (req_fire) begin
                aw_ptr <= aw_ptr + PTR_W'(1);
            end
            if (rsp_take) begin
                ar_ptr <= ar_ptr + PTR_W'(1);
            end
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_take);

            // Everything issued up to and including the redirect cycle is stale.
            if (redirect_valid) begin
                pc       <= align_word(redirect_pc);
                drop_cnt <= outstanding - CNT_W'(rsp_take) + CNT_W'(req_fire);
            end else begin
                if (req_fire) begin
                    pc <= pc + 64'd4;
                end
                if (rsp_take && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            addr_mem[aw_ptr] <= pc;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (q_push),
        .push_entry (rsp_entry),
        .pop        (q_pop),
        .head       (q_head),
        .count      (q_count),
        .empty      (q_empty)
    );

    assign inst_valid_o = !q_empty;
    assign inst_o       = inst_valid_o ? q_head.data : INST_NOP;
    assign inst_addr_o  = inst_valid_o ? q_head.addr : 64'd0;

    a_credit : assert property (@(posedge clk) disable iff (!rst_n)
        credit_used <= (CNT_W+1)'(DEPTH));
    a_drop : assert property (@(posedge clk) disable iff (!rst_n)
        drop_cnt <= outstanding);

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: acts as instruction memory (data = addr[31:0])
// and decode, and scores every word handed to decode against an expected queue.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    typedef struct packed {
        logic [63:0] addr;
        logic        drop;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [63:0] inst_addr_o;

    pend_t        pending[$];
    fetch_entry_t sb[$];
    fetch_entry_t rsp_entry;
    logic         rsp_active;
    logic         rsp_live;
    logic         rsp_hold;
    int           stray_cycles;
    logic [63:0]  exp_pc;
    logic [63:0]  last_pop_addr;
    int           hs_cnt;
    int           pop_cnt;
    int           total;
    int           bad;

    always #5 clk = ~clk;

    if_fetch #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid_o   (inst_valid_o),
        .inst_ready_i   (inst_ready_i),
        .inst_o         (inst_o),
        .inst_addr_o    (inst_addr_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs at negedge, update the model at posedge, drive next inputs.
    task automatic cycle();
        logic         hs;
        logic         redir;
        logic         exp_valid;
        logic [63:0]  addr;
        fetch_entry_t e;
        pend_t        p;
        @(negedge clk);
        hs    = imem_req_valid && imem_req_ready;
        addr  = imem_req_addr;
        redir = redirect_valid;
        exp_valid = rst_n && ((pending.size() + int'(rsp_active) + sb.size()) < DEPTH);
        check("req_valid", 64'(imem_req_valid), 64'(exp_valid));
        if (imem_req_valid) check("req_addr", imem_req_addr, exp_pc);
        check("inst_valid", 64'(inst_valid_o), 64'(sb.size() != 0));
        if (inst_valid_o) begin
            if (inst_ready_i && sb.size() != 0) begin
                e = sb.pop_front();
                check("inst_addr", inst_addr_o, e.addr);
                check("inst_data", 64'(inst_o), 64'(e.data));
                pop_cnt++;
                last_pop_addr = inst_addr_o;
            end
        end else begin
            check("idle_inst_nop", 64'(inst_o), 64'(INST_NOP));
            check("idle_inst_addr", inst_addr_o, 64'd0);
        end
        @(posedge clk);
        if (!rst_n) begin
            sb.delete();
            pending.delete();
            exp_pc = RST_PC;
        end else begin
            if (rsp_active && rsp_live && !redir) sb.push_back(rsp_entry);
            if (hs) begin
                pending.push_back('{addr: addr, drop: 1'b0});
                exp_pc = exp_pc + 64'd4;
                hs_cnt++;
            end
            if (redir) begin
                sb.delete();
                foreach (pending[i]) pending[i].drop = 1'b1;
                exp_pc = {redirect_pc[63:2], 2'b00};
            end
        end
        #1;
        redirect_valid = 1'b0;
        rsp_active     = 1'b0;
        rsp_live       = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        if (stray_cycles > 0) begin
            stray_cycles--;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hdead_beef;
        end else if (!rsp_hold && pending.size() != 0) begin
            p              = pending.pop_front();
            rsp_active     = 1'b1;
            rsp_live       = !p.drop;
            rsp_entry      = '{addr: p.addr, data: p.addr[31:0]};
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = p.addr[31:0];
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain();
        imem_req_ready = 1'b0;
        inst_ready_i   = 1'b1;
        rsp_hold       = 1'b0;
        for (int i = 0; i < 40 && (pending.size() != 0 || sb.size() != 0 || rsp_active); i++) cycle();
        check("drain_empty", 64'(pending.size() + sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          h0;
        int          p0;
        logic [63:0] a0;
        total = 0; bad = 0; hs_cnt = 0; pop_cnt = 0;
        rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        redirect_valid = 1'b0; redirect_pc = 64'd0; inst_ready_i = 1'b1;
        rsp_hold = 1'b0; stray_cycles = 0; rsp_active = 1'b0; rsp_live = 1'b0;
        rsp_entry = '0; exp_pc = RST_PC; last_pop_addr = 64'd0;

        // Reset: hold low, then first request must target RESET_PC.
        @(posedge clk); #1;
        run(2);
        rst_n = 1'b1;
        #1;
        check("rst_req_valid", 64'(imem_req_valid), 64'd1);
        check("rst_req_addr", imem_req_addr, RST_PC);
        check("rst_inst_valid", 64'(inst_valid_o), 64'd0);
        check("rst_inst_nop", 64'(inst_o), 64'(INST_NOP));

        // Streaming: first word arrives two cycles after the first request, then 1/cycle.
        run(3);
        check("stream_first_addr", last_pop_addr, RST_PC);
        run(2);
        p0 = pop_cnt;
        run(10);
        check("stream_throughput", 64'(pop_cnt - p0), 64'd10);
        drain();

        // Backpressure from decode: credits allow exactly DEPTH requests.
        inst_ready_i = 1'b0; imem_req_ready = 1'b1;
        h0 = hs_cnt;
        run(10);
        check("bp_req_count", 64'(hs_cnt - h0), 64'(DEPTH));
        imem_req_ready = 1'b0; inst_ready_i = 1'b1;
        p0 = pop_cnt;
        run(6);
        check("bp_release_pops", 64'(pop_cnt - p0), 64'(DEPTH));
        drain();

        // Redirect with two fetches in flight: both returns are dropped.
        rsp_hold = 1'b1; imem_req_ready = 1'b1;
        run(2);
        check("redir_inflight", 64'(pending.size()), 64'd2);
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_1002;
        cycle();
        rsp_hold = 1'b0;
        check("redir_req_addr", imem_req_addr, 64'h8000_1000);
        p0 = pop_cnt;
        run(3);
        check("redir_no_stale", 64'(pop_cnt - p0), 64'd0);
        imem_req_ready = 1'b1;
        run(3);
        check("redir_first_addr", last_pop_addr, 64'h8000_1000);

        // Redirect in the middle of a full-rate stream (same-cycle request and response).
        run(4);
        redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_0000_0103;
        cycle();
        run(3);
        check("redir_stream_addr", last_pop_addr, 64'h0000_0000_0000_0100);
        run(4);
        drain();

        // Request stall: address and PC hold; a redirect during the stall takes over.
        imem_req_ready = 1'b0;
        cycle();
        a0 = imem_req_addr;
        h0 = hs_cnt;
        run(5);
        check("stall_addr_stable", imem_req_addr, a0);
        check("stall_no_issue", 64'(hs_cnt - h0), 64'd0);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2004;
        cycle();
        check("stall_redir_addr", imem_req_addr, 64'h8000_2004);
        imem_req_ready = 1'b1;
        run(6);
        drain();

        // PC wraps at the top of the 64-bit space.
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF9;
        cycle();
        imem_req_ready = 1'b1;
        run(5);
        check("wrap_addr", last_pop_addr, 64'd0);
        drain();

        // Mid-operation reset with three in flight; late responses are strays.
        rsp_hold = 1'b1; imem_req_ready = 1'b1;
        run(3);
        check("mid_rst_inflight", 64'(pending.size()), 64'd3);
        imem_req_ready = 1'b0; rst_n = 1'b0;
        cycle();
        rst_n = 1'b1; rsp_hold = 1'b0; stray_cycles = 3;
        run(3);
        check("mid_rst_no_word", 64'(inst_valid_o), 64'd0);
        check("mid_rst_req_addr", imem_req_addr, RST_PC);
        imem_req_ready = 1'b1;
        run(3);
        check("mid_rst_first_addr", last_pop_addr, RST_PC);
        run(4);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
